// File: rtl/prim_secded_72_64_rsp.sv
// prim_secded_72_64_rsp: post-SECDED read response stage with a 2-deep FIFO, error counters, a first-error log and a scrub request slot.
module prim_secded_72_64_rsp #(
  parameter int AW   = 32,
  parameter int CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [AW-1:0]   in_addr_i,
  input  logic [63:0]     in_data_i,
  input  logic [7:0]      in_syndrome_i,
  input  logic [1:0]      in_err_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [63:0]     out_data_o,
  output logic [1:0]      out_err_o,
  output logic            scrub_req_o,
  input  logic            scrub_gnt_i,
  output logic [AW-1:0]   scrub_addr_o,
  output logic [63:0]     scrub_data_o,
  output logic            scrub_drop_o,
  input  logic            clear_i,
  output logic [CntW-1:0] cnt_ce_o,
  output logic [CntW-1:0] cnt_ue_o,
  output logic            log_valid_o,
  output logic            log_ue_o,
  output logic [AW-1:0]   log_addr_o,
  output logic [7:0]      log_syndrome_o
);
  logic [65:0]     r_mem [2];
  logic            r_rd, r_wr;
  logic [1:0]      r_cnt;
  logic [CntW-1:0] r_cnt_ce, r_cnt_ue;
  logic            r_log_valid, r_log_ue;
  logic [AW-1:0]   r_log_addr;
  logic [7:0]      r_log_syn;
  logic            r_scrub_req, r_drop;
  logic [AW-1:0]   r_scrub_addr;
  logic [63:0]     r_scrub_data;
  logic            w_push, w_pop, w_ce, w_ue, w_drop, w_log_ld;

  assign in_ready_o     = r_cnt != 2'd2;
  assign out_valid_o    = r_cnt != 2'd0;
  assign {out_data_o, out_err_o} = r_mem[r_rd];
  assign w_push         = in_valid_i & in_ready_o;
  assign w_pop          = out_valid_o & out_ready_i;
  // 2'b11 counts as uncorrectable only
  assign w_ce           = w_push & (in_err_i == 2'b01);
  assign w_ue           = w_push & in_err_i[1];
  assign w_drop         = w_ce & r_scrub_req & ~scrub_gnt_i;
  assign w_log_ld       = (w_ce | w_ue) & (clear_i | ~r_log_valid | (w_ue & ~r_log_ue));
  assign cnt_ce_o       = r_cnt_ce;
  assign cnt_ue_o       = r_cnt_ue;
  assign log_valid_o    = r_log_valid;
  assign log_ue_o       = r_log_ue;
  assign log_addr_o     = r_log_addr;
  assign log_syndrome_o = r_log_syn;
  assign scrub_req_o    = r_scrub_req;
  assign scrub_addr_o   = r_scrub_addr;
  assign scrub_data_o   = r_scrub_data;
  assign scrub_drop_o   = r_drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem[0]     <= '0;
      r_mem[1]     <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_cnt        <= '0;
      r_cnt_ce     <= '0;
      r_cnt_ue     <= '0;
      r_log_valid  <= 1'b0;
      r_log_ue     <= 1'b0;
      r_log_addr   <= '0;
      r_log_syn    <= '0;
      r_scrub_req  <= 1'b0;
      r_scrub_addr <= '0;
      r_scrub_data <= '0;
      r_drop       <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {in_data_i, in_err_i};
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt    <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      r_cnt_ce <= clear_i ? CntW'(w_ce) : r_cnt_ce + CntW'(w_ce & ~&r_cnt_ce);
      r_cnt_ue <= clear_i ? CntW'(w_ue) : r_cnt_ue + CntW'(w_ue & ~&r_cnt_ue);
      if (w_log_ld) begin
        r_log_valid <= 1'b1;
        r_log_ue    <= w_ue;
        r_log_addr  <= in_addr_i;
        r_log_syn   <= in_syndrome_i;
      end else if (clear_i) begin
        r_log_valid <= 1'b0;
        r_log_ue    <= 1'b0;
        r_log_addr  <= '0;
        r_log_syn   <= '0;
      end
      if (w_ce & ~w_drop) begin
        r_scrub_req  <= 1'b1;
        r_scrub_addr <= in_addr_i;
        r_scrub_data <= in_data_i;
      end else if (scrub_gnt_i) begin
        r_scrub_req  <= 1'b0;
      end
      r_drop <= w_drop | (r_drop & ~clear_i);
    end
  end
endmodule

// File: tb/tb_prim_secded_72_64_rsp.sv
// tb_prim_secded_72_64_rsp: directed and random stimulus checked against a queue-based reference model.
module tb_prim_secded_72_64_rsp;
  localparam int AW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst_ni = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, scrub_gnt = 1'b0, clear = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [63:0]   in_data = '0;
  logic [7:0]    in_syn = '0;
  logic [1:0]    in_err = '0;
  logic          in_ready_o, out_valid_o, scrub_req_o, scrub_drop_o, log_valid_o, log_ue_o;
  logic [63:0]   out_data_o, scrub_data_o;
  logic [1:0]    out_err_o;
  logic [AW-1:0] scrub_addr_o, log_addr_o;
  logic [CW-1:0] cnt_ce_o, cnt_ue_o;
  logic [7:0]    log_syndrome_o;

  int n_assert = 0, n_fail = 0;

  logic [63:0]   q_d[$];
  logic [1:0]    q_e[$];
  int            m_ce, m_ue;
  bit            m_lv, m_lue, m_req, m_drop;
  logic [AW-1:0] m_la, m_sa;
  logic [7:0]    m_ls;
  logic [63:0]   m_sd;

  prim_secded_72_64_rsp #(.AW(AW), .CntW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_addr_i(in_addr),
    .in_data_i(in_data), .in_syndrome_i(in_syn), .in_err_i(in_err),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o), .out_err_o(out_err_o),
    .scrub_req_o(scrub_req_o), .scrub_gnt_i(scrub_gnt), .scrub_addr_o(scrub_addr_o),
    .scrub_data_o(scrub_data_o), .scrub_drop_o(scrub_drop_o), .clear_i(clear),
    .cnt_ce_o(cnt_ce_o), .cnt_ue_o(cnt_ue_o), .log_valid_o(log_valid_o), .log_ue_o(log_ue_o),
    .log_addr_o(log_addr_o), .log_syndrome_o(log_syndrome_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_d.delete(); q_e.delete();
    m_ce = 0; m_ue = 0; m_lv = 0; m_lue = 0; m_la = '0; m_ls = '0;
    m_req = 0; m_sa = '0; m_sd = '0; m_drop = 0;
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_out_err", out_err_o, 0);
    chk("rst_scrub_req", scrub_req_o, 0);
    chk("rst_scrub_addr", scrub_addr_o, 0);
    chk("rst_scrub_data", scrub_data_o, 0);
    chk("rst_scrub_drop", scrub_drop_o, 0);
    chk("rst_cnt_ce", cnt_ce_o, 0);
    chk("rst_cnt_ue", cnt_ue_o, 0);
    chk("rst_log_valid", log_valid_o, 0);
    chk("rst_log_ue", log_ue_o, 0);
    chk("rst_log_addr", log_addr_o, 0);
    chk("rst_log_syn", log_syndrome_o, 0);
  endtask

  task automatic cycle(input bit v, input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s,
                       input logic [1:0] e, input bit ordy, input bit gnt, input bit clr);
    bit acc, ce_ev, ue_ev;
    in_valid = v; in_addr = a; in_data = d; in_syn = s; in_err = e;
    out_ready = ordy; scrub_gnt = gnt; clear = clr;
    #1;
    chk("in_ready", in_ready_o, q_d.size() < 2);
    chk("out_valid", out_valid_o, q_d.size() > 0);
    if (q_d.size() > 0) begin
      chk("out_data", out_data_o, q_d[0]);
      chk("out_err", out_err_o, q_e[0]);
    end
    chk("cnt_ce", cnt_ce_o, m_ce);
    chk("cnt_ue", cnt_ue_o, m_ue);
    chk("log_valid", log_valid_o, m_lv);
    if (m_lv) begin
      chk("log_ue", log_ue_o, m_lue);
      chk("log_addr", log_addr_o, m_la);
      chk("log_syn", log_syndrome_o, m_ls);
    end
    chk("scrub_req", scrub_req_o, m_req);
    if (m_req) begin
      chk("scrub_addr", scrub_addr_o, m_sa);
      chk("scrub_data", scrub_data_o, m_sd);
    end
    chk("scrub_drop", scrub_drop_o, m_drop);
    acc   = v && q_d.size() < 2;
    ce_ev = acc && e == 2'b01;
    ue_ev = acc && e[1];
    if (ordy && q_d.size() > 0) begin
      void'(q_d.pop_front());
      void'(q_e.pop_front());
    end
    if (acc) begin
      q_d.push_back(d);
      q_e.push_back(e);
    end
    if (clr) begin m_ce = 0; m_ue = 0; m_lv = 0; m_lue = 0; end
    if (ce_ev && m_ce < CMAX) m_ce++;
    if (ue_ev && m_ue < CMAX) m_ue++;
    if ((ce_ev || ue_ev) && (!m_lv || (ue_ev && !m_lue))) begin
      m_lv = 1; m_lue = ue_ev; m_la = a; m_ls = s;
    end
    if (clr) m_drop = 0;
    if (ce_ev && m_req && !gnt) m_drop = 1;
    else if (ce_ev) begin m_req = 1; m_sa = a; m_sd = d; end
    else if (gnt) m_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit ordy, input bit gnt, input bit clr);
    cycle(0, '0, '0, '0, 2'b00, ordy, gnt, clr);
  endtask

  initial begin
    logic [63:0] d;
    int r;
    model_reset();
    #1;
    chk_reset();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) cycle(1, AW'(i * 4), {$urandom, $urandom}, '0, 2'b00, 1, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);

    cycle(1, 32'h10, 64'hAAAA_0000_0000_000A, '0, 2'b00, 0, 0, 0);
    cycle(1, 32'h14, 64'hBBBB_0000_0000_000B, '0, 2'b00, 0, 0, 0);
    cycle(1, 32'h18, 64'hCCCC_0000_0000_000C, '0, 2'b00, 0, 0, 0);
    chk("full_ready_low", in_ready_o, 0);
    cycle(1, 32'h18, 64'hCCCC_0000_0000_000C, '0, 2'b00, 1, 0, 0);
    cycle(1, 32'h18, 64'hCCCC_0000_0000_000C, '0, 2'b00, 1, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);

    cycle(1, 32'h100, 64'h1111_2222_3333_4444, 8'h07, 2'b01, 1, 0, 0);
    chk("ce_scrub_addr", scrub_addr_o, 32'h100);
    cycle(1, 32'h104, 64'h5555_6666_7777_8888, 8'h09, 2'b01, 1, 0, 0);
    chk("ce_drop", scrub_drop_o, 1);
    chk("ce_cnt2", cnt_ce_o, 2);
    chk("ce_log_addr", log_addr_o, 32'h100);
    idle(1, 0, 0);
    idle(1, 1, 0);
    idle(1, 0, 1);

    cycle(1, 32'h200, {$urandom, $urandom}, 8'h05, 2'b01, 1, 1, 0);
    cycle(1, 32'h300, {$urandom, $urandom}, 8'h03, 2'b10, 1, 1, 0);
    cycle(1, 32'h400, {$urandom, $urandom}, 8'h0B, 2'b11, 1, 1, 0);
    chk("ue_log_addr", log_addr_o, 32'h300);
    chk("ue_log_ue", log_ue_o, 1);
    chk("ue_cnt_ue", cnt_ue_o, 2);
    chk("ue_cnt_ce", cnt_ce_o, 1);
    idle(1, 0, 1);

    for (int i = 0; i < 17; i++) cycle(1, AW'(32'h1000 + i), {$urandom, $urandom}, 8'h01, 2'b01, 1, 1, 0);
    chk("sat_cnt_ce", cnt_ce_o, 4'hF);
    cycle(1, 32'h500, {$urandom, $urandom}, 8'h11, 2'b01, 1, 1, 1);
    chk("clr_ce_cnt", cnt_ce_o, 1);
    chk("clr_ce_log", log_addr_o, 32'h500);
    idle(1, 1, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      d = {$urandom, $urandom};
      cycle($urandom_range(0, 3) != 0, $urandom, d, 8'($urandom),
            r < 6 ? 2'b00 : r < 8 ? 2'b01 : r < 9 ? 2'b10 : 2'b11,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
    end

    idle(1, 1, 1);
    cycle(1, 32'h600, {$urandom, $urandom}, 8'h21, 2'b01, 0, 0, 0);
    cycle(1, 32'h604, {$urandom, $urandom}, 8'h00, 2'b00, 0, 0, 0);
    chk("pre_rst_full", in_ready_o, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset();
    model_reset();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    idle(1, 0, 0);
    idle(1, 0, 0);
    cycle(1, 32'h700, 64'hDEAD_BEEF_0123_4567, 8'h00, 2'b00, 1, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/prim_secded_72_64_rsp.md
# prim_secded_72_64_rsp

Read-response stage directly downstream of the 72/64 SECDED decoder on the memory read path. Accepts one decoded beat per cycle (corrected data, syndrome, error flags, address) and buffers it in a 2-entry response FIFO toward the requester. It also keeps saturating error counters and a first-error log, and issues a single-slot scrub write-back request with corrected data for every correctable error it can service.

## Interface
- AW, 32, address width of read beats and scrub requests
- CntW, 16, width of correctable/uncorrectable error counters
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  decoded beat valid
- in_ready_o  out  1  stage can accept a beat
- in_addr_i  in  AW  word address of beat
- in_data_i  in  64  corrected data from decoder
- in_syndrome_i  in  8  decoder syndrome
- in_err_i  in  2  [0]=correctable (CE), [1]=uncorrectable (UE)
- out_valid_o  out  1  response valid
- out_ready_i  in  1  requester accepts response
- out_data_o  out  64  response data
- out_err_o  out  2  error flags carried with the beat
- scrub_req_o  out  1  scrub write-back request
- scrub_gnt_i  in  1  write port accepts scrub
- scrub_addr_o  out  AW  scrub address
- scrub_data_o  out  64  corrected data to re-encode and write
- scrub_drop_o  out  1  sticky: a CE scrub was dropped
- clear_i  in  1  clears counters, log, scrub_drop_o
- cnt_ce_o  out  CntW  correctable error count
- cnt_ue_o  out  CntW  uncorrectable error count
- log_valid_o  out  1  log holds an error
- log_ue_o  out  1  logged error is UE
- log_addr_o  out  AW  logged address
- log_syndrome_o  out  8  logged syndrome

## Operation
- Accept = in_valid_i & in_ready_o. in_err_i==2'b11 is treated as UE only (no CE count, no scrub).
- Response FIFO: 2 entries, storing {data, err}; order preserved. in_ready_o = (count<2), no combinational path from out_ready_i. out_valid_o = (count>0); head held stable until out_ready_i.
- Push and pop in same cycle: count unchanged. When full, in_ready_o=0 even if out_ready_i=1 this cycle.
- Counters: +1 on accepted CE / UE; saturate at all-ones (no wrap). clear_i resets to 0; clear_i and an event in the same cycle yields 1.
- Log: when log_valid_o=0, first accepted CE or UE loads addr, syndrome, log_ue_o and sets log_valid_o. An accepted UE overwrites a logged CE; nothing else overwrites. clear_i empties the log; simultaneous event is logged.
- Scrub slot states: IDLE, PEND. IDLE + accepted CE -> PEND, load in_addr_i/in_data_i. PEND + scrub_gnt_i -> IDLE, unless an accepted CE in the same cycle, which reloads and stays PEND. PEND, no grant, accepted CE -> beat dropped, scrub_drop_o set (sticky until clear_i; clear_i with simultaneous drop leaves it set).
- scrub_addr_o/scrub_data_o stable while scrub_req_o=1. Scrub never stalls the response path.

## Timing
- Reset (async assert, sync-released use on next edge): FIFO empty, out_valid_o=0, out_data_o=0, out_err_o=0, in_ready_o=1, scrub_req_o=0, scrub_addr_o=0, scrub_data_o=0, scrub_drop_o=0, counters 0, log_* all 0.
- Latency: beat accepted at edge N appears on out_* after edge N (visible cycle N+1) when FIFO empty; full throughput 1 beat/cycle with out_ready_i=1.
- Counters, log and scrub_req_o update on the edge of acceptance (visible next cycle).
- Reset asserted mid-transfer discards FIFO contents and pending scrub immediately.

## Test plan
- Stream 8 clean beats (err=0) with out_ready_i=1 -> same data out in order, 1 cycle latency, in_ready_o never drops, counters 0, log_valid_o=0.
- Hold out_ready_i=0, present 3 beats -> 2 accepted, in_ready_o=0 on third; release -> A,B out then C accepted; no loss or reorder.
- CE at addr 0x100, syndrome 0x07 -> cnt_ce_o=1, log {0x100,0x07,ue=0}, scrub_req_o=1 with addr 0x100 until gnt; second CE before gnt -> scrub_drop_o=1, cnt_ce_o=2, log unchanged.
- CE at 0x200 then UE at 0x300 syndrome 0x03 -> log_ue_o=1, log_addr_o=0x300, cnt_ue_o=1, no scrub for UE; in_err_i=2'b11 -> only cnt_ue_o increments.
- Force cnt_ce_o to all-ones via 2^CntW CEs (CntW=4 build: 16) -> holds 0xF on 17th; clear_i with simultaneous CE -> cnt_ce_o=1, log holds that CE.
- Assert rst_ni low with 2 beats buffered and scrub pending -> all outputs at reset values asynchronously; no stale beat after release.
